// File: rtl/cpu_types_pkg.sv
// Shared instruction-cache types: fetch address split, frame layout, controller states.
// Frame count is a power of two with one 32-bit word per frame.
package cpu_types_pkg;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;

  typedef enum logic {
    IDLE,
    FETCH
  } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave is the cache's view; master is the datapath/controller view.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_frames.sv
// Direct-mapped frame store: combinational read port, one clocked write port.
// Only the valid bits are reset; tag and data are qualified by valid.
module icache_frames
  import cpu_types_pkg::*;
(
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [ICACHE_IDX_W-1:0] ridx,
  output icache_frame_t           rframe,
  input  logic                    wen,
  input  logic [ICACHE_IDX_W-1:0] widx,
  input  logic [ICACHE_TAG_W-1:0] wtag,
  input  logic [31:0]             wdata
);

  logic [ICACHE_SETS-1:0]  valid;
  logic [ICACHE_TAG_W-1:0] tags  [ICACHE_SETS];
  logic [31:0]             words [ICACHE_SETS];

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
    end else if (wen) begin
      valid[widx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wen) begin
      tags[widx]  <= wtag;
      words[widx] <= wdata;
    end
  end

  always_comb begin
    rframe       = '0;
    rframe.valid = valid[ridx];
    rframe.tag   = tags[ridx];
    rframe.data  = words[ridx];
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only icache: same-cycle hit, miss stalls fetch and fills one word via iREN/iwait.
// Optional hit/miss counters when ICACHE_STATS_EN is defined.
module icache
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  icache_if.slave     cif
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  icachef_t      faddr;
  icache_frame_t rframe;
  icache_state_t state;
  logic [29:0]   fill_waddr;
  logic          iren_r;
  logic          hit_raw;
  logic          miss_req;
  logic          fill_done;
  logic          unused_bytoff;

  assign faddr         = icachef_t'(cif.imemaddr);
  assign unused_bytoff = ^faddr.bytoff;

  icache_frames u_frames (
    .CLK    (CLK),
    .nRST   (nRST),
    .ridx   (faddr.idx),
    .rframe (rframe),
    .wen    (fill_done),
    .widx   (fill_waddr[ICACHE_IDX_W-1:0]),
    .wtag   (fill_waddr[29:ICACHE_IDX_W]),
    .wdata  (cif.iload)
  );

  assign hit_raw   = rframe.valid && (rframe.tag == faddr.tag);
  assign miss_req  = (state == IDLE) && cif.imemREN && !hit_raw;
  assign fill_done = (state == FETCH) && !cif.iwait;

  assign cif.ihit     = (state == IDLE) && cif.imemREN && hit_raw;
  assign cif.imemload = cif.ihit ? rframe.data : 32'h0;
  assign cif.iREN     = iren_r;
  assign cif.iaddr    = {fill_waddr, 2'b00};

  // The fill always finishes to the latched address, even if fetch redirects meanwhile.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      iren_r     <= 1'b0;
      fill_waddr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_req) begin
            state      <= FETCH;
            iren_r     <= 1'b1;
            fill_waddr <= cif.imemaddr[31:2];
          end
        end
        FETCH: begin
          if (!cif.iwait) begin
            state  <= IDLE;
            iren_r <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          iren_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (cif.ihit) hit_cnt  <= hit_cnt + 32'd1;
      if (miss_req) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed plus randomized fetch traffic against a word-address cache model.
module tb_icache;

  logic CLK = 1'b0;
  logic nRST;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  icache_if cif ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
  icache dut (.CLK(CLK), .nRST(nRST), .cif(cif), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));
`else
  icache dut (.CLK(CLK), .nRST(nRST), .cif(cif));
`endif

  // Backing memory: contents derived from the word address; word 0 holds 0x8C010004.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E3779B1) ^ 32'h8C010004;
  endfunction

  always_comb cif.iload = memw(cif.iaddr);

  // Model: which word address each of the 16 frames currently holds.
  bit          m_valid [16];
  logic [29:0] m_word  [16];
  int          exp_hits = 0;
  int          exp_miss = 0;

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[5:2]] && (m_word[a[5:2]] == a[31:2]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
  endtask

  task automatic do_reset();
    cif.imemREN = 1'b0; cif.imemaddr = 32'h0; cif.iwait = 1'b1;
    nRST = 1'b0;
    model_clear();
    step(); step();
    nRST = 1'b1;
    @(negedge CLK);
    chk("rst_ihit", {31'd0, cif.ihit}, 32'd0);
    chk("rst_iREN", {31'd0, cif.iREN}, 32'd0);
    chk("rst_iaddr", cif.iaddr, 32'd0);
`ifdef ICACHE_STATS_EN
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif
    step();
  endtask

  task automatic idle_cycle();
    cif.imemREN  = 1'b0;
    cif.imemaddr = $urandom;
    cif.iwait    = 1'b1;
    @(negedge CLK);
    chk("idle_ihit", {31'd0, cif.ihit}, 32'd0);
    chk("idle_iREN", {31'd0, cif.iREN}, 32'd0);
    step();
  endtask

  // One fetch of a; on a miss the controller waits nwait cycles. With redir the
  // fetch address (and optionally imemREN) changes while the fill is in flight.
  task automatic fetch(input logic [31:0] a, input int nwait, input bit redir,
                       input logic [31:0] ra, input bit drop);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    cif.imemREN = 1'b1; cif.imemaddr = a; cif.iwait = 1'b1;
    if (model_hit(a)) begin
      @(negedge CLK);
      chk("hit_ihit", {31'd0, cif.ihit}, 32'd1);
      chk("hit_data", cif.imemload, memw(a));
      chk("hit_iREN", {31'd0, cif.iREN}, 32'd0);
      exp_hits++;
      step();
    end else begin
      @(negedge CLK);
      chk("miss_ihit", {31'd0, cif.ihit}, 32'd0);
      chk("miss_data", cif.imemload, 32'd0);
      chk("miss_iREN", {31'd0, cif.iREN}, 32'd0);
      exp_miss++;
      step();
      if (redir) begin
        cif.imemaddr = ra;
        cif.imemREN  = !drop;
      end
      for (int i = 0; i <= nwait; i++) begin
        cif.iwait = (i < nwait);
        @(negedge CLK);
        chk("fill_iREN", {31'd0, cif.iREN}, 32'd1);
        chk("fill_iaddr", cif.iaddr, wa);
        chk("fill_ihit", {31'd0, cif.ihit}, 32'd0);
        step();
      end
      cif.iwait = 1'b1;
      m_valid[a[5:2]] = 1'b1;
      m_word[a[5:2]]  = a[31:2];
      if (!redir) begin
        @(negedge CLK);
        chk("post_fill_ihit", {31'd0, cif.ihit}, 32'd1);
        chk("post_fill_data", cif.imemload, memw(a));
        chk("post_fill_iREN", {31'd0, cif.iREN}, 32'd0);
        exp_hits++;
        step();
      end
    end
  endtask

  initial begin
    cif.imemREN = 1'b0; cif.imemaddr = 32'h0; cif.iwait = 1'b1;
    nRST = 1'b0;
    #1;
    do_reset();

    // Cold miss with three wait cycles, then fill the rest of the first 16 words.
    fetch(32'h0, 3, 1'b0, 32'h0, 1'b0);
    for (int i = 1; i < 16; i++) fetch(32'(i * 4), $urandom_range(0, 2), 1'b0, 32'h0, 1'b0);
`ifdef ICACHE_STATS_EN
    @(negedge CLK);
    chk("stats_miss16", miss_cnt, 32'd16);
    chk("stats_hit16", hit_cnt, 32'd16);
    step();
`endif
    // Replay: every word must hit, including with nonzero byte offsets.
    for (int i = 0; i < 16; i++) begin
      if (!model_hit(32'(i * 4))) begin
        errors++;
        $display("FAIL model_replay: word %0d not resident in model", i);
      end
      fetch(32'(i * 4) | 32'($urandom_range(0, 3)), 0, 1'b0, 32'h0, 1'b0);
    end
    idle_cycle();

    // Conflict on index 0.
    fetch(32'h40, 1, 1'b0, 32'h0, 1'b0);
    fetch(32'h00, 0, 1'b0, 32'h0, 1'b0);
    fetch(32'h40, 2, 1'b0, 32'h0, 1'b0);

    // Redirect mid-fill; then imemREN drop mid-fill.
    do_reset();
    fetch(32'h10, 3, 1'b1, 32'h200, 1'b0);
    fetch(32'h200, 1, 1'b0, 32'h0, 1'b0);
    fetch(32'h10, 0, 1'b0, 32'h0, 1'b0);
    fetch(32'h24, 2, 1'b1, 32'h0, 1'b1);
    idle_cycle();
    fetch(32'h24, 0, 1'b0, 32'h0, 1'b0);

    // Reset during FETCH: iREN must drop without a clock edge.
    cif.imemREN = 1'b1; cif.imemaddr = 32'h84; cif.iwait = 1'b1;
    step();
    @(negedge CLK);
    chk("pre_rst_iREN", {31'd0, cif.iREN}, 32'd1);
    #1 nRST = 1'b0;
    #1 chk("async_rst_iREN", {31'd0, cif.iREN}, 32'd0);
    model_clear();
    step();
    nRST = 1'b1;
    fetch(32'h10, 1, 1'b0, 32'h0, 1'b0);

    // Random traffic over 48 words (3 per frame) with two tag regions.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, ra;
      int r;
      a  = (32'($urandom_range(0, 47)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a[31] = 1'b1;
      ra = (32'($urandom_range(0, 47)) << 2);
      r  = $urandom_range(0, 9);
      if (r == 0)      idle_cycle();
      else if (r == 1) fetch(a, $urandom_range(0, 3), 1'b1, ra, $urandom_range(0, 1) == 1);
      else             fetch(a, $urandom_range(0, 3), 1'b0, 32'h0, 1'b0);
    end

`ifdef ICACHE_STATS_EN
    @(negedge CLK);
    chk("stats_hit_final", hit_cnt, 32'(exp_hits));
    chk("stats_miss_final", miss_cnt, 32'(exp_miss));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
